// File: rtl/triangle_sequencer.sv
// Run controller for a triangle wave generator: clears it, strobes its step
// enable at a programmed rate for a programmed number of periods, then reports done.
module triangle_sequencer #(
    parameter int N     = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [7:0]       periods,
    output logic             gen_clr,
    output logic             gen_ena,
    output logic             busy,
    output logic             done,
    output logic [7:0]       period_idx
);

    localparam int            PS        = 2 * ((2 ** N) - 1);
    localparam int            SC_W      = N + 1;
    localparam logic [N:0]    LAST_STEP = SC_W'(PS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       periods_q;
    logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [N:0]       step_cnt_q, step_cnt_d;
    logic [7:0]       period_idx_q, period_idx_d;
    logic             strobe;
    logic             final_step;

    // Stop masks the strobe in the same cycle, so it wins over a final step.
    assign strobe     = (state_q == RUN) && (pre_cnt_q == '0) && !stop;
    assign final_step = (periods_q != 8'd0) && (step_cnt_q == LAST_STEP) &&
                        (period_idx_q == periods_q - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            periods_q    <= '0;
            pre_cnt_q    <= '0;
            step_cnt_q   <= '0;
            period_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            step_cnt_q   <= step_cnt_d;
            period_idx_q <= period_idx_d;
            if (state_q == IDLE && start) begin
                div_q     <= div;
                periods_q <= periods;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        step_cnt_d   = step_cnt_q;
        period_idx_d = period_idx_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                step_cnt_d   = '0;
                period_idx_d = '0;
                pre_cnt_d    = div_q;
                state_d      = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (pre_cnt_q == '0) begin
                    pre_cnt_d = div_q;
                    if (step_cnt_q == LAST_STEP) begin
                        step_cnt_d   = '0;
                        period_idx_d = period_idx_q + 8'd1;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                    if (final_step) state_d = DONE;
                end else begin
                    pre_cnt_d = pre_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gen_clr    = (state_q == CLEAR);
        gen_ena    = strobe;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        period_idx = period_idx_q;
    end

endmodule

// File: tb/tb_triangle_sequencer.sv
// Directed bench for triangle_sequencer with N=3 (14 steps per period),
// including a reference triangle generator driven by the sequencer outputs.
module tb_triangle_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [15:0] div_i;
    logic [7:0]  periods_i;
    logic        gen_clr, gen_ena, busy, done;
    logic [7:0]  period_idx;
    logic [2:0]  gv;
    logic        up;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    triangle_sequencer #(.N(3), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .div(div_i),
        .periods(periods_i), .gen_clr(gen_clr), .gen_ena(gen_ena),
        .busy(busy), .done(done), .period_idx(period_idx)
    );

    // Reference 3-bit triangle generator fed by the controller.
    always_ff @(posedge clk) begin
        if (rst || gen_clr) begin
            gv <= 3'd0;
            up <= 1'b1;
        end else if (gen_ena) begin
            if (up) begin
                if (gv == 3'd7) begin gv <= 3'd6; up <= 1'b0; end
                else gv <= gv + 3'd1;
            end else begin
                if (gv == 3'd0) begin gv <= 3'd1; up <= 1'b1; end
                else gv <= gv - 3'd1;
            end
        end
    end

    typedef struct {
        int dv; int per; int stop_k; int glitch_k; int max_k;
        int n; int first; int last; int done_k; int ndone; int busy_low;
    } vec_t;

    vec_t vecs[7];

    function automatic int tri_val(input int j);
        int m;
        m = j % 14;
        return (m <= 7) ? m : 14 - m;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycle k counts from the CLEAR cycle (k=1) after the accepted start edge.
    task automatic run_vec(input vec_t v, input int vi);
        int n = 0, first = 0, last = 0, done_k = 0, ndone = 0, busy_low = 0;
        int sp_err = 0, idx_err = 0, tr_err = 0, clr_err = 0, leak = 0, prev = 0;
        @(negedge clk);
        start = 1'b1; div_i = 16'(v.dv); periods_i = 8'(v.per);
        for (int k = 1; k <= v.max_k; k++) begin
            @(negedge clk);
            stop  = (k == v.stop_k);
            start = (v.glitch_k != 0) && (k == v.glitch_k);
            if (start) begin div_i = 16'd0; periods_i = 8'd5; end
            #1;
            if (gen_clr != (k == 1)) clr_err++;
            if (stop && gen_ena) leak++;
            if (gen_ena) begin
                n++;
                if (n == 1) first = k;
                else if (k - prev != v.dv + 1) sp_err++;
                prev = k;
                last = k;
                if (int'(period_idx) != ((n - 1) / 14) % 256) idx_err++;
                if (int'(gv) != tri_val(n - 1)) tr_err++;
            end
            if (done) begin ndone++; done_k = k; end
            if (!busy && busy_low == 0) busy_low = k;
        end
        stop = 1'b0; start = 1'b0;
        check($sformatf("v%0d strobes", vi), n, v.n);
        check($sformatf("v%0d first", vi), first, v.first);
        check($sformatf("v%0d last", vi), last, v.last);
        check($sformatf("v%0d done_cycle", vi), done_k, v.done_k);
        check($sformatf("v%0d done_pulses", vi), ndone, v.ndone);
        check($sformatf("v%0d busy_low", vi), busy_low, v.busy_low);
        check($sformatf("v%0d spacing_err", vi), sp_err, 0);
        check($sformatf("v%0d period_idx_err", vi), idx_err, 0);
        check($sformatf("v%0d trace_err", vi), tr_err, 0);
        check($sformatf("v%0d clr_err", vi), clr_err, 0);
        check($sformatf("v%0d ena_during_stop", vi), leak, 0);
    endtask

    initial begin
        //          dv per stop glt max   n first last done nd blow
        vecs[0] = '{0, 1, 0,   0,  22,  14, 2,   15,  16,  1, 17};
        vecs[1] = '{2, 2, 0,   0,  92,  28, 4,   85,  86,  1, 87};
        vecs[2] = '{1, 1, 0,   0,  36,  14, 3,   29,  30,  1, 31};
        vecs[3] = '{3, 3, 0,   0,  176, 42, 5,   169, 170, 1, 171};
        vecs[4] = '{0, 0, 150, 0,  160, 148, 2,  149, 0,   0, 151};
        vecs[5] = '{0, 1, 15,  0,  22,  13, 2,   14,  0,   0, 16};
        vecs[6] = '{2, 1, 0,   10, 50,  14, 4,   43,  44,  1, 45};

        rst = 1'b1; start = 1'b0; stop = 1'b0; div_i = '0; periods_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst gen_clr", int'(gen_clr), 0);
        check("rst gen_ena", int'(gen_ena), 0);
        check("rst period_idx", int'(period_idx), 0);
        rst = 1'b0;

        // Reset in the middle of a continuous-looking run (3 periods, div 0).
        @(negedge clk);
        start = 1'b1; div_i = 16'd0; periods_i = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("midrun period_idx", int'(period_idx), 2);
        check("midrun busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst gen_clr", int'(gen_clr), 0);
        check("midrst gen_ena", int'(gen_ena), 0);
        check("midrst period_idx", int'(period_idx), 0);
        check("midrst gen_out", int'(gv), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
